// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
// Frame field widths, opcode/turnaround codes and the skip lengths for aborted frames.
package mdio_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHY,
        S_REG,
        S_TA,
        S_WDATA,
        S_RDATA,
        S_SKIP
    } mdio_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    // Bit times left in the frame once the PHY field or a bad write TA is seen.
    localparam int SKIP_PHY_BITS   = REGAD_W + 2 + DATA_W;
    localparam int SKIP_WDATA_BITS = DATA_W;

endpackage

// File: rtl/mdio_responder_if.sv
// MDIO pad and register-port bundle between the responder and its environment.
// slave = responder view, master = bench / PHY register-file view.
interface mdio_responder_if;
    import mdio_pkg::*;

    logic                 mdc;
    logic                 mdio_i;
    logic                 mdio_o;
    logic                 mdio_oe;
    logic [REGAD_W-1:0]   reg_addr;
    logic                 reg_rd_en;
    logic [DATA_W-1:0]    reg_rd_data;
    logic                 reg_wr_en;
    logic [DATA_W-1:0]    reg_wr_data;
    logic                 frame_err;

    modport slave (
        input  mdc, mdio_i, reg_rd_data,
        output mdio_o, mdio_oe, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, frame_err
    );

    modport master (
        output mdc, mdio_i, reg_rd_data,
        input  mdio_o, mdio_oe, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, frame_err
    );

endinterface

// File: rtl/mdc_edge_detect.sv
// Synchronizes MDC into clk and emits one-clk rise/fall pulses.
// Latency: SYNC_STAGES+1 clks from pad edge to pulse; no backpressure.
module mdc_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc_i,
    output logic mdc_rise_o,
    output logic mdc_fall_o
);

    logic mdc_s;
    logic mdc_prev_q;
    logic rise_q;
    logic fall_q;

    synchronizer #(.STAGES(SYNC_STAGES)) u_mdc_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (mdc_i),
        .q_o   (mdc_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdc_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            mdc_prev_q <= mdc_s;
            rise_q     <= mdc_s & ~mdc_prev_q;
            fall_q     <= ~mdc_s & mdc_prev_q;
        end
    end

    assign mdc_rise_o = rise_q;
    assign mdc_fall_o = fall_q;

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit, resets to 0.
// Latency: STAGES clks; no backpressure.
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES:0]   taps;

    assign taps = {sync_q, d_i};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= taps[STAGES-1:0];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder: samples on MDC rise, drives read data on MDC fall.
// Latency: strobes 1 clk after the deciding mdc_rise, pad drive 1 clk after mdc_fall; no backpressure.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHYAD       = 5'd1,
    parameter int                 PRE_LEN     = 32,
    parameter int                 SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mdio_responder_if.slave    bus
);

    localparam int                PRE_W   = $clog2(PRE_LEN + 1);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRE_LEN);

    logic mdc_rise;
    logic mdc_fall;
    logic mdio_s;

    mdio_state_t         state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic                is_read_q, is_read_d;
    logic                cap_q;
    logic [REGAD_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                ferr_q, ferr_d;
    logic                mdio_o_q, mdio_o_d;
    logic                mdio_oe_q, mdio_oe_d;

    mdc_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .mdc_i      (bus.mdc),
        .mdc_rise_o (mdc_rise),
        .mdc_fall_o (mdc_fall)
    );

    synchronizer #(.STAGES(SYNC_STAGES)) u_mdio_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.mdio_i),
        .q_o   (mdio_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            cnt_q     <= '0;
            sh_q      <= '0;
            is_read_q <= 1'b0;
            cap_q     <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            ferr_q    <= 1'b0;
            mdio_o_q  <= 1'b0;
            mdio_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            is_read_q <= is_read_d;
            cap_q     <= rd_en_q;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            ferr_q    <= ferr_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        ferr_d    = 1'b0;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;

        // Register file answers the clk after reg_rd_en; load it here during TA.
        if (cap_q) begin
            sh_d = bus.reg_rd_data;
        end

        case (state_q)
            S_IDLE: begin
                if (mdc_rise) begin
                    if (mdio_s) begin
                        if (pre_q != PRE_MAX) begin
                            pre_d = pre_q + PRE_W'(1);
                        end
                    end else begin
                        if (pre_q == PRE_MAX) begin
                            state_d = S_ST;
                        end
                        pre_d = '0;
                    end
                end
            end
            S_ST: begin
                if (mdc_rise) begin
                    cnt_d   = '0;
                    state_d = mdio_s ? S_OP : S_IDLE;
                end
            end
            S_OP: begin
                if (mdc_rise) begin
                    sh_d = {sh_q[DATA_W-2:0], mdio_s};
                    if (cnt_q == 5'd0) begin
                        cnt_d = 5'd1;
                    end else begin
                        cnt_d = '0;
                        case ({sh_q[0], mdio_s})
                            OP_READ: begin
                                is_read_d = 1'b1;
                                state_d   = S_PHY;
                            end
                            OP_WRITE: begin
                                is_read_d = 1'b0;
                                state_d   = S_PHY;
                            end
                            default: begin
                                ferr_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            end
            S_PHY: begin
                if (mdc_rise) begin
                    sh_d = {sh_q[DATA_W-2:0], mdio_s};
                    if (cnt_q == 5'(PHYAD_W - 1)) begin
                        if ({sh_q[PHYAD_W-2:0], mdio_s} == PHYAD) begin
                            cnt_d   = '0;
                            state_d = S_REG;
                        end else begin
                            cnt_d   = 5'(SKIP_PHY_BITS);
                            state_d = S_SKIP;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_REG: begin
                if (mdc_rise) begin
                    sh_d = {sh_q[DATA_W-2:0], mdio_s};
                    if (cnt_q == 5'(REGAD_W - 1)) begin
                        addr_d  = {sh_q[REGAD_W-2:0], mdio_s};
                        rd_en_d = is_read_q;
                        cnt_d   = '0;
                        state_d = S_TA;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_TA: begin
                if (mdc_rise) begin
                    if (!is_read_q) begin
                        sh_d = {sh_q[DATA_W-2:0], mdio_s};
                    end
                    if (cnt_q == 5'd0) begin
                        cnt_d = 5'd1;
                    end else if (is_read_q) begin
                        cnt_d   = '0;
                        state_d = S_RDATA;
                    end else if ({sh_q[0], mdio_s} == TA_WRITE) begin
                        cnt_d   = '0;
                        state_d = S_WDATA;
                    end else begin
                        ferr_d  = 1'b1;
                        cnt_d   = 5'(SKIP_WDATA_BITS);
                        state_d = S_SKIP;
                    end
                end else if (mdc_fall && is_read_q && cnt_q == 5'd1) begin
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = 1'b0;
                end
            end
            S_WDATA: begin
                if (mdc_rise) begin
                    sh_d = {sh_q[DATA_W-2:0], mdio_s};
                    if (cnt_q == 5'(DATA_W - 1)) begin
                        wr_en_d = 1'b1;
                        wdat_d  = {sh_q[DATA_W-2:0], mdio_s};
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_RDATA: begin
                // cnt_q counts bits already driven; the 17th fall releases the pad.
                if (mdc_fall) begin
                    if (cnt_q == 5'(DATA_W)) begin
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b0;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        mdio_o_d = sh_q[DATA_W-1];
                        sh_d     = {sh_q[DATA_W-2:0], 1'b0};
                        cnt_d    = cnt_q + 5'd1;
                    end
                end
            end
            S_SKIP: begin
                if (mdc_rise) begin
                    if (cnt_q <= 5'd1) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && state_d == S_IDLE) begin
            pre_d = '0;
        end
    end

    assign bus.mdio_o      = mdio_o_q;
    assign bus.mdio_oe     = mdio_oe_q;
    assign bus.reg_addr    = addr_q;
    assign bus.reg_rd_en   = rd_en_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_data = wdat_q;
    assign bus.frame_err   = ferr_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench acting as MAC-side MDIO master plus a registered PHY register file.
module tb_mdio_responder;

    localparam int HALF = 8;

    typedef struct {
        int          pre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [1:0]  ta;
        logic [15:0] wd;
        bit          rel;
        int          exp_wr;
        int          exp_rd;
        int          exp_fe;
        logic [4:0]  exp_addr;
        logic [15:0] exp_data;
        bit          exp_oe;
    } vec_t;

    logic clk;
    logic rst_n;
    logic mdc_r;
    logic m_oe;
    logic m_val;
    logic pad;
    logic [15:0] rd_data_r;
    logic [15:0] mem [32];

    int n_assert;
    int n_fail;
    int n_wr, n_rd, n_fe, n_oe;
    int excl_err, width_err;
    logic [4:0]  last_addr;
    logic [15:0] last_wdat;
    logic prev_wr, prev_rd, prev_fe;

    mdio_responder_if bus ();

    mdio_responder #(
        .PHYAD       (5'd1),
        .PRE_LEN     (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign pad             = bus.mdio_oe ? bus.mdio_o : (m_oe ? m_val : 1'b1);
    assign bus.mdc         = mdc_r;
    assign bus.mdio_i      = pad;
    assign bus.reg_rd_data = rd_data_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.reg_rd_en) rd_data_r <= mem[bus.reg_addr];
    end

    initial begin
        n_wr = 0; n_rd = 0; n_fe = 0; n_oe = 0;
        excl_err = 0; width_err = 0;
        last_addr = '0; last_wdat = '0;
        prev_wr = 1'b0; prev_rd = 1'b0; prev_fe = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.reg_wr_en) begin
                n_wr++;
                last_addr = bus.reg_addr;
                last_wdat = bus.reg_wr_data;
            end
            if (bus.reg_rd_en) begin
                n_rd++;
                last_addr = bus.reg_addr;
            end
            if (bus.frame_err) n_fe++;
            if (bus.mdio_oe) n_oe++;
            if ((int'(bus.reg_wr_en) + int'(bus.reg_rd_en) + int'(bus.frame_err)) > 1) excl_err++;
            if ((bus.reg_wr_en && prev_wr) || (bus.reg_rd_en && prev_rd) || (bus.frame_err && prev_fe))
                width_err++;
            prev_wr = bus.reg_wr_en;
            prev_rd = bus.reg_rd_en;
            prev_fe = bus.frame_err;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit drv, output logic s_pad, output logic s_oe);
        mdc_r = 1'b0;
        m_oe  = drv;
        m_val = b;
        repeat (HALF) @(negedge clk);
        s_pad = pad;
        s_oe  = bus.mdio_oe;
        mdc_r = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v, input int stop_after,
                             output logic ta1_oe, output logic ta2_pad, output logic [15:0] rword);
        int n;
        logic sp, so;
        logic [13:0] hdr;
        n = 0; ta1_oe = 1'b0; ta2_pad = 1'b1; rword = '0;
        hdr = {2'b01, v.op, v.phy, v.rg};
        for (int i = 0; i < v.pre; i++) begin
            send_bit(1'b1, 1'b1, sp, so);
            n++;
            if (n == stop_after) return;
        end
        for (int i = 13; i >= 0; i--) begin
            send_bit(hdr[i], 1'b1, sp, so);
            n++;
            if (n == stop_after) return;
        end
        for (int i = 1; i >= 0; i--) begin
            send_bit(v.ta[i], !v.rel, sp, so);
            if (i == 1) ta1_oe = so;
            else        ta2_pad = sp;
            n++;
            if (n == stop_after) return;
        end
        for (int i = 15; i >= 0; i--) begin
            send_bit(v.wd[i], !v.rel, sp, so);
            rword[i] = sp;
            n++;
            if (n == stop_after) return;
        end
        // Trailing fall only: no extra rise, so the preamble count stays at 0.
        mdc_r = 1'b0;
        m_oe  = 1'b0;
        repeat (HALF + 4) @(negedge clk);
    endtask

    vec_t vecs [11];

    initial begin
        logic t1, t2;
        logic [15:0] rw;
        int b_wr, b_rd, b_fe, b_oe;
        vec_t rv;

        n_assert = 0;
        n_fail   = 0;
        mdc_r = 1'b0; m_oe = 1'b0; m_val = 1'b1;
        rd_data_r = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[2] = 16'h1234;
        mem[9] = 16'hBEEF;

        //         pre op     phy    rg     ta     wd        rel wr rd fe addr   data      oe
        vecs[0]  = '{32, 2'b01, 5'h01, 5'h03, 2'b10, 16'hA5C3, 0, 1, 0, 0, 5'h03, 16'hA5C3, 0};
        vecs[1]  = '{32, 2'b10, 5'h01, 5'h02, 2'b10, 16'h0000, 1, 0, 1, 0, 5'h02, 16'h1234, 1};
        vecs[2]  = '{32, 2'b10, 5'h07, 5'h02, 2'b10, 16'h0000, 1, 0, 0, 0, 5'h00, 16'h0000, 0};
        vecs[3]  = '{32, 2'b01, 5'h01, 5'h04, 2'b10, 16'h0F0F, 0, 1, 0, 0, 5'h04, 16'h0F0F, 0};
        vecs[4]  = '{31, 2'b01, 5'h01, 5'h05, 2'b10, 16'h1111, 0, 0, 0, 0, 5'h00, 16'h0000, 0};
        vecs[5]  = '{32, 2'b01, 5'h01, 5'h05, 2'b10, 16'h1111, 0, 1, 0, 0, 5'h05, 16'h1111, 0};
        vecs[6]  = '{32, 2'b11, 5'h01, 5'h06, 2'b10, 16'h2222, 0, 0, 0, 1, 5'h00, 16'h0000, 0};
        vecs[7]  = '{32, 2'b01, 5'h01, 5'h06, 2'b11, 16'h2222, 0, 0, 0, 1, 5'h00, 16'h0000, 0};
        vecs[8]  = '{32, 2'b00, 5'h01, 5'h06, 2'b10, 16'h3333, 0, 0, 0, 1, 5'h00, 16'h0000, 0};
        vecs[9]  = '{40, 2'b01, 5'h01, 5'h1F, 2'b10, 16'hFFFF, 0, 1, 0, 0, 5'h1F, 16'hFFFF, 0};
        vecs[10] = '{32, 2'b10, 5'h01, 5'h09, 2'b10, 16'h0000, 1, 0, 1, 0, 5'h09, 16'hBEEF, 1};

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset mdio_oe",      32'(bus.mdio_oe),     32'd0);
        chk("reset mdio_o",       32'(bus.mdio_o),      32'd0);
        chk("reset reg_rd_en",    32'(bus.reg_rd_en),   32'd0);
        chk("reset reg_wr_en",    32'(bus.reg_wr_en),   32'd0);
        chk("reset frame_err",    32'(bus.frame_err),   32'd0);
        chk("reset reg_addr",     32'(bus.reg_addr),    32'd0);
        chk("reset reg_wr_data",  32'(bus.reg_wr_data), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            b_wr = n_wr; b_rd = n_rd; b_fe = n_fe; b_oe = n_oe;
            run_frame(vecs[i], 0, t1, t2, rw);
            chk($sformatf("v%0d wr_count", i), 32'(n_wr - b_wr), 32'(vecs[i].exp_wr));
            chk($sformatf("v%0d rd_count", i), 32'(n_rd - b_rd), 32'(vecs[i].exp_rd));
            chk($sformatf("v%0d ferr_count", i), 32'(n_fe - b_fe), 32'(vecs[i].exp_fe));
            chk($sformatf("v%0d oe_seen", i), 32'(n_oe > b_oe), 32'(vecs[i].exp_oe));
            chk($sformatf("v%0d oe_after", i), 32'(bus.mdio_oe), 32'd0);
            if (vecs[i].exp_wr != 0) begin
                chk($sformatf("v%0d wr_addr", i), 32'(last_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("v%0d wr_data", i), 32'(last_wdat), 32'(vecs[i].exp_data));
            end
            if (vecs[i].exp_rd != 0) begin
                chk($sformatf("v%0d rd_addr", i), 32'(last_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("v%0d ta1_oe", i), 32'(t1), 32'd0);
                chk($sformatf("v%0d ta2_pad", i), 32'(t2), 32'd0);
                chk($sformatf("v%0d rd_word", i), 32'(rw), 32'(vecs[i].exp_data));
            end
        end

        // Reset while driving read data bit 8 of a read of reg 2.
        rv = vecs[1];
        b_wr = n_wr; b_fe = n_fe;
        run_frame(rv, 32 + 14 + 2 + 8, t1, t2, rw);
        chk("midread oe driving", 32'(bus.mdio_oe), 32'd1);
        chk("midread bits 15..8", 32'(rw[15:8]), 32'h12);
        rst_n = 1'b0;
        b_rd = n_rd;
        @(negedge clk);
        chk("midreset oe released", 32'(bus.mdio_oe), 32'd0);
        mdc_r = 1'b0;
        m_oe  = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midreset no strobes", 32'((n_rd - b_rd) + (n_wr - b_wr) + (n_fe - b_fe)), 32'd0);

        rv = vecs[10];
        b_rd = n_rd;
        run_frame(rv, 0, t1, t2, rw);
        chk("post-reset rd_count", 32'(n_rd - b_rd), 32'd1);
        chk("post-reset rd_addr", 32'(last_addr), 32'h09);
        chk("post-reset ta2_pad", 32'(t2), 32'd0);
        chk("post-reset rd_word", 32'(rw), 32'hBEEF);
        chk("post-reset oe_after", 32'(bus.mdio_oe), 32'd0);

        chk("strobe exclusivity", 32'(excl_err), 32'd0);
        chk("strobe width", 32'(width_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
